// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART transmit types and constants, plus a width helper for
// counters that must stay at least one bit wide.
package tt_devmonk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

  function automatic int clog2_min1(input int value);
    return ($clog2(value) < 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with a registered occupancy count and a combinational
// head read; writes when full and reads when empty are ignored.
module sync_fifo
  import tt_devmonk_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = clog2_min1(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally; the count alone tells full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO; frames are sent LSB-first
// back-to-back while data is queued, and ena freezes the bit engine.
module uart_tx_fifo
  import tt_devmonk_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic [7:0]                  wr_data,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int TW = clog2_min1(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    DATA_LAST = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(UART_STOP_BITS - 1);

  tx_state_t     state;
  tx_state_t     state_next;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          bit_done;
  logic          line_bit;

  sync_fifo #(
    .WIDTH(UART_DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (wr_valid),
    .push_data(wr_data),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign wr_ready = !fifo_full;
  assign busy     = (state != IDLE) || !fifo_empty;
  assign bit_done = (timer == BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // The STOP exit pops the next byte directly so queued frames have no gap.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    line_bit   = 1'b1;
    case (state)
      IDLE: begin
        if (ena && !fifo_empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        line_bit = 1'b0;
        if (ena && bit_done) state_next = DATA;
      end
      DATA: begin
        line_bit = shift[0];
        if (ena && bit_done && bit_idx == DATA_LAST) state_next = STOP;
      end
      STOP: begin
        if (ena && bit_done && bit_idx == STOP_LAST) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // tx is registered from the current state, so it trails the state by a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else if (ena) begin
      tx    <= line_bit;
      timer <= (state == IDLE || bit_done) ? '0 : timer + 1'b1;
      case (state)
        IDLE:  bit_idx <= '0;
        START: if (bit_done) bit_idx <= '0;
        DATA: begin
          if (bit_done) begin
            shift   <= shift >> 1;
            bit_idx <= (bit_idx == DATA_LAST) ? '0 : bit_idx + 1'b1;
          end
        end
        STOP: if (bit_done) bit_idx <= (bit_idx == STOP_LAST) ? '0 : bit_idx + 1'b1;
        default: bit_idx <= '0;
      endcase
      if (pop) shift <= head;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised scoreboard bench for uart_tx_fifo: a frame-level model predicts the
// line and queue, and a line monitor decodes frames against expected bytes.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       ena      = 1'b0;
  logic [7:0] wr_data  = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  int tests  = 0;
  int failed = 0;
  bit armed  = 1'b0;

  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  bit         m_active = 1'b0;
  int         m_rem    = 0;
  logic [7:0] m_frame  = 8'h00;
  logic       m_tx     = 1'b1;
  bit         edge_adv = 1'b0;
  bit         m_push;
  bit         m_pop;
  int         m_bit;

  bit         mon_busy   = 1'b0;
  int         mon_n      = 0;
  int         mon_bit    = 0;
  int         mon_frames = 0;
  logic [7:0] mon_byte   = 8'h00;

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .tx        (tx),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] data, input logic valid, input logic en, input logic rs);
    wr_data  = data;
    wr_valid = valid;
    ena      = en;
    rst      = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((m_active || m_q.size() != 0) && n < limit) begin
      apply_stimulus(8'h00, 1'b0, 1'b1, 1'b0);
      n++;
    end
    check_output("drain_busy", 32'(busy), 32'(0));
    check_output("drain_outstanding", 32'(exp_q.size()), 32'(0));
  endtask

  // Reference model: a frame occupies FRAME enabled edges after its pop, the line
  // shows frame position (FRAME - remaining) one edge later, and the queue refills
  // the engine either when idle or at the edge that ends the stop bit.
  always @(posedge clk) begin
    edge_adv = !rst && ena;
    if (rst) begin
      m_q.delete();
      exp_q.delete();
      m_active = 1'b0;
      m_rem    = 0;
      m_tx     = 1'b1;
    end else begin
      m_push = wr_valid && (m_q.size() < DEPTH);
      m_pop  = 1'b0;
      if (ena) begin
        if (m_active) begin
          m_bit = (FRAME - m_rem) / CPB;
          m_tx  = (m_bit == 0) ? 1'b0 : (m_bit == 9) ? 1'b1 : m_frame[m_bit-1];
          m_rem--;
          if (m_rem == 0) begin
            if (m_q.size() != 0) m_pop = 1'b1;
            else                 m_active = 1'b0;
          end
        end else begin
          m_tx = 1'b1;
          if (m_q.size() != 0) m_pop = 1'b1;
        end
      end
      if (m_pop) begin
        m_frame  = m_q.pop_front();
        m_active = 1'b1;
        m_rem    = FRAME;
        exp_q.push_back(m_frame);
      end
      if (m_push) m_q.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check_output("tx", 32'(tx), 32'(m_tx));
      check_output("busy", 32'(busy), 32'(m_active || m_q.size() != 0));
      check_output("fifo_count", 32'(fifo_count), 32'(m_q.size()));
      check_output("wr_ready", 32'(wr_ready), 32'(m_q.size() != DEPTH));
    end
  end

  // Line monitor: counts only cycles whose opening edge had ena, samples mid-bit.
  always @(negedge clk) begin
    if (!armed || rst) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (tx === 1'b0) begin
        mon_busy = 1'b1;
        mon_n    = 0;
      end
    end else if (edge_adv) begin
      mon_n++;
      if (mon_n % CPB == CPB / 2) begin
        mon_bit = mon_n / CPB;
        if (mon_bit == 0) begin
          check_output("start_bit", 32'(tx), 32'(0));
        end else if (mon_bit <= 8) begin
          mon_byte[mon_bit-1] = tx;
        end else begin
          check_output("stop_bit", 32'(tx), 32'(1));
          mon_frames++;
          check_output("frame_expected", 32'(exp_q.size() != 0), 32'(1));
          if (exp_q.size() != 0) check_output("frame_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
          mon_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [9:0] a5_frame;
    logic [7:0] rnd;
    int         f0;
    a5_frame = 10'b1101001010;

    repeat (3) apply_stimulus(8'h00, 1'b0, 1'b1, 1'b1);
    armed = 1'b1;
    check_output("reset_tx", 32'(tx), 32'(1));
    check_output("reset_busy", 32'(busy), 32'(0));
    check_output("reset_count", 32'(fifo_count), 32'(0));
    check_output("reset_wr_ready", 32'(wr_ready), 32'(1));
    apply_stimulus(8'h00, 1'b0, 1'b1, 1'b0);

    // Single 0xA5 frame: latency, bit pattern and busy release.
    apply_stimulus(8'hA5, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 42; k++) begin
      apply_stimulus(8'h00, 1'b0, 1'b1, 1'b0);
      if (k >= 2 && k <= 41) check_output("a5_bit", 32'(tx), 32'(a5_frame[(k-2)/CPB]));
      if (k == 38) check_output("a5_busy_stop", 32'(busy), 32'(1));
      if (k == 42) check_output("a5_busy_after", 32'(busy), 32'(0));
    end

    f0 = mon_frames;
    apply_stimulus(8'h00, 1'b1, 1'b1, 1'b0);
    check_output("b2b_count0", 32'(fifo_count), 32'(1));
    apply_stimulus(8'hFF, 1'b1, 1'b1, 1'b0);
    check_output("b2b_count1", 32'(fifo_count), 32'(1));
    apply_stimulus(8'h3C, 1'b1, 1'b1, 1'b0);
    check_output("b2b_count2", 32'(fifo_count), 32'(2));
    wait_idle(400);
    check_output("b2b_frames", 32'(mon_frames - f0), 32'(3));

    f0 = mon_frames;
    apply_stimulus(8'($urandom), 1'b1, 1'b1, 1'b0);
    apply_stimulus(8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      rnd = 8'($urandom);
      apply_stimulus(rnd, 1'b1, 1'b1, 1'b0);
      check_output("full_count", 32'(fifo_count), 32'((i + 1 < DEPTH) ? i + 1 : DEPTH));
    end
    check_output("full_wr_ready", 32'(wr_ready), 32'(0));
    wait_idle(400);
    check_output("full_frames", 32'(mon_frames - f0), 32'(5));

    // 0x81 with ena dropped for 7 edges during data bit 1.
    f0 = mon_frames;
    apply_stimulus(8'h81, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 48; k++) begin
      apply_stimulus(8'h00, 1'b0, (k < 14 || k > 20) ? 1'b1 : 1'b0, 1'b0);
      if (k >= 14 && k <= 20) check_output("freeze_tx", 32'(tx), 32'(0));
      if (k == 47) check_output("freeze_busy_late", 32'(busy), 32'(1));
      if (k == 48) check_output("freeze_busy_done", 32'(busy), 32'(0));
    end
    check_output("freeze_frames", 32'(mon_frames - f0), 32'(1));

    // Reset during data bit 3 of 0x55 with two bytes still queued.
    apply_stimulus(8'h55, 1'b1, 1'b1, 1'b0);
    apply_stimulus(8'h12, 1'b1, 1'b1, 1'b0);
    apply_stimulus(8'h34, 1'b1, 1'b1, 1'b0);
    for (int k = 3; k <= 19; k++) apply_stimulus(8'h00, 1'b0, 1'b1, 1'b0);
    apply_stimulus(8'h00, 1'b0, 1'b1, 1'b1);
    check_output("abort_tx", 32'(tx), 32'(1));
    check_output("abort_count", 32'(fifo_count), 32'(0));
    check_output("abort_busy", 32'(busy), 32'(0));
    f0 = mon_frames;
    repeat (60) apply_stimulus(8'h00, 1'b0, 1'b1, 1'b0);
    check_output("abort_frames", 32'(mon_frames - f0), 32'(0));

    // Push on the same edge the next byte is popped, with two bytes queued.
    f0 = mon_frames;
    apply_stimulus(8'hC1, 1'b1, 1'b1, 1'b0);
    apply_stimulus(8'h7E, 1'b1, 1'b1, 1'b0);
    apply_stimulus(8'h09, 1'b1, 1'b1, 1'b0);
    for (int k = 3; k <= 40; k++) apply_stimulus(8'h00, 1'b0, 1'b1, 1'b0);
    check_output("pushpop_before", 32'(fifo_count), 32'(2));
    apply_stimulus(8'hE4, 1'b1, 1'b1, 1'b0);
    check_output("pushpop_after", 32'(fifo_count), 32'(2));
    wait_idle(400);
    check_output("pushpop_frames", 32'(mon_frames - f0), 32'(4));

    for (int i = 0; i < 1500; i++) begin
      apply_stimulus(8'($urandom), ($urandom_range(2, 0) == 0), ($urandom_range(7, 0) != 0),
                     ($urandom_range(499, 0) == 0));
    end
    wait_idle(600);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Serial transmit engine inside tt_um_devmonkZA_10. It drives one dedicated output pin, uo_out[0], as an 8N1 UART line. It is the sending end of the pin link whose receiving end is the cocotb bench watching uo_out. Bytes are pushed through a valid/ready port into a small FIFO and serialised LSB-first at a fixed clocks-per-bit rate.

Parameters:
CLKS_PER_BIT, 4, clock cycles per serial bit; legal range 2..65535; counter width is $clog2(CLKS_PER_BIT).
FIFO_DEPTH, 4, byte entries; power of two, minimum 2.

Ports:
clk  input  1  system clock; the only clock.
rst  input  1  synchronous, active-high reset; top level ties it to ~rst_n.
ena  input  1  global enable; when 0 the bit timer and FSM freeze.
wr_data  input  8  byte to enqueue.
wr_valid  input  1  enqueue request.
wr_ready  output  1  high when the FIFO is not full.
tx  output  1  serial line; idle high; mapped to uo_out[0].
busy  output  1  high while a frame is in flight or the FIFO is non-empty.
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset, sampled on a clk edge with rst=1:
  - tx=1, busy=0, fifo_count=0, wr_ready=1.
  - FSM goes to IDLE; FIFO pointers, bit timer and bit index are cleared.
  - Reset mid-frame aborts the frame. tx returns high on the next cycle; no partial bits are resent.
- Enqueue:
  - A byte is accepted on any edge where wr_valid && wr_ready, regardless of ena.
  - wr_ready = (fifo_count != FIFO_DEPTH), combinational from registered count.
  - When full, the write is ignored. There is no write-through on the same edge as a pop.
- Simultaneous push and pop: fifo_count is unchanged and both pointers advance.
- FSM states: IDLE, START, DATA, STOP. All transitions below happen only when ena=1.
  - IDLE: if fifo_count>0, pop the head into the shift register, go to START, clear timer.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right. After bit index 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then:
    - if fifo_count>0, pop and go directly to START (no idle gap between frames);
    - otherwise go to IDLE.
- tx is a register, so it is glitch-free.
- Latency:
  - Byte accepted in cycle c with the FIFO empty and FSM in IDLE: tx first goes low in cycle c+2.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
- ena=0:
  - Timer, bit index and state hold; tx holds its current value.
  - FIFO still accepts writes.
  - Resuming ena continues the current bit with the remaining count.
- busy = (state!=IDLE) || (fifo_count!=0).
- Pointer wrap: the pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. fifo_count is tracked separately to distinguish full from empty.
- No X may propagate to tx from uninitialised FIFO storage. Only popped entries are read.

Decomposition:
- Package tt_devmonk_pkg holds:
  - state enum tx_state_t {IDLE, START, DATA, STOP};
  - constants UART_DATA_BITS=8 and UART_STOP_BITS=1;
  - a function clog2_min1 used for counter widths.
- One sub-module, sync_fifo: parameterised width and depth, push/pop/count. It is reusable by a future uart_rx.
- The top-level shell maps rst=~rst_n, tx to uo_out[0], and wr_* from ui_in/uio_in.

Test Plan:
- CLKS_PER_BIT=4, reset, then write 0xA5 in one cycle.
  - tx low at cycle +2.
  - tx then presents bits 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), 4 cycles each.
  - busy drops on the first cycle after the stop bit.
- Write 0x00, 0xFF, 0x3C on consecutive cycles.
  - Three frames go out back-to-back with no idle cycle; total 120 cycles of activity.
  - fifo_count sequence after the pushes: 1, 1, 2 (the first byte is popped immediately).
- Hold wr_valid for 6 cycles while the FSM is busy, FIFO_DEPTH=4.
  - wr_ready deasserts once fifo_count reaches 4.
  - The extra bytes are dropped; exactly 5 frames are transmitted, the first already in flight.
- Mid-DATA of 0x81: drop ena for 7 cycles.
  - tx and the timer hold for those 7 cycles.
  - The frame completes 7 cycles late with the correct bits.
- Assert rst during bit 3 of 0x55 while 2 bytes are queued.
  - Next cycle: tx=1, fifo_count=0, busy=0.
  - No further frames appear within 60 cycles.
- Push and pop on the same edge while fifo_count=2: fifo_count stays 2, and the byte order is preserved on the line.
